// File: rtl/map_gen_if.sv
// Handshake and map-RAM write bundle for map_gen.
interface map_gen_if;
    logic        start;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic        edit_valid;
    logic        edit_ready;
    logic [14:0] edit_addr;
    logic [3:0]  edit_data;
    logic [14:0] write_addr;
    logic [3:0]  write_data;
    logic        write_en;

    modport master (
        output start, seed, edit_valid, edit_addr, edit_data,
        input  busy, done, edit_ready, write_addr, write_data, write_en
    );
    modport slave (
        input  start, seed, edit_valid, edit_addr, edit_data,
        output busy, done, edit_ready, write_addr, write_data, write_en
    );
endinterface

// File: rtl/map_gen.sv
// Voxel map generator: fills a 32x32x32 block map column by column, plus single-block edits.
// Define MAP_GEN_TERRAIN_EN for LFSR-driven random-walk terrain; otherwise the surface is flat.
module map_gen #(
    parameter int BASE_HEIGHT = 12,
    parameter int MIN_HEIGHT  = 4,
    parameter int MAX_HEIGHT  = 24,
    parameter int DIRT_DEPTH  = 3
) (
    input logic       clk,
    input logic       rst,
    map_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t      state, state_n;
    logic [14:0] cnt;
    logic [4:0]  h_q, h_new;
    logic [4:0]  y;
    logic [5:0]  y_dirt;
    logic [3:0]  blk;
    logic        col_beat, start_acc, edit_acc;
    logic [14:0] wa_q;
    logic [3:0]  wd_q;
    logic        we_q, done_q;

    assign y          = cnt[4:0];
    assign y_dirt     = {1'b0, y} + 6'(DIRT_DEPTH);
    assign col_beat   = (y == 5'd0);
    assign start_acc  = bus.start && (state != FILL);
    assign edit_acc   = bus.edit_valid && bus.edit_ready;

    assign bus.edit_ready = (state != FILL) && !bus.start;
    assign bus.busy       = (state == FILL);
    assign bus.done       = done_q;
    assign bus.write_en   = we_q;
    assign bus.write_addr = wa_q;
    assign bus.write_data = wd_q;

`ifdef MAP_GEN_TERRAIN_EN
    logic [15:0] lfsr, lfsr_step, seed_ld;

    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign seed_ld   = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;

    // Random walk on the pre-step LFSR bits, clamped to the legal surface band.
    always_comb begin
        h_new = h_q;
        case (lfsr[1:0])
            2'b00:   h_new = (h_q > 5'(MIN_HEIGHT)) ? h_q - 5'd1 : 5'(MIN_HEIGHT);
            2'b11:   h_new = (h_q < 5'(MAX_HEIGHT)) ? h_q + 5'd1 : 5'(MAX_HEIGHT);
            default: h_new = h_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          lfsr <= 16'hACE1;
        else if (start_acc)               lfsr <= seed_ld;
        else if (state == FILL && col_beat) lfsr <= lfsr_step;
    end
`else
    logic unused_seed;
    assign unused_seed = ^bus.seed;
    assign h_new       = 5'(BASE_HEIGHT);
`endif

    // y==0 is always bedrock, so the held height only matters from y==1 onward.
    always_comb begin
        if (col_beat)                 blk = 4'd4;
        else if (y > h_q)             blk = 4'd0;
        else if (y == h_q)            blk = 4'd1;
        else if (y_dirt >= {1'b0, h_q}) blk = 4'd2;
        else                          blk = 4'd3;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = FILL;
            FILL:    if (cnt == 15'h7FFF) state_n = DONE;
            DONE:    if (bus.start) state_n = FILL;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            h_q    <= 5'(BASE_HEIGHT);
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            done_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start_acc) begin
                cnt    <= '0;
                h_q    <= 5'(BASE_HEIGHT);
                done_q <= 1'b0;
            end else if (state == FILL) begin
                we_q <= 1'b1;
                wa_q <= {cnt[4:0], cnt[14:5]};
                wd_q <= blk;
                cnt  <= cnt + 15'd1;
                if (col_beat)          h_q    <= h_new;
                if (cnt == 15'h7FFF)   done_q <= 1'b1;
            end else if (edit_acc) begin
                we_q <= 1'b1;
                wa_q <= bus.edit_addr;
                wd_q <= bus.edit_data;
            end
        end
    end
endmodule

// File: tb/tb_map_gen.sv
// Self-checking bench for map_gen: scoreboard of expected RAM writes plus table-driven edits/map probes.
module tb_map_gen;
    localparam int BASE = 12;
    localparam int MINH = 4;
    localparam int MAXH = 24;
    localparam int DIRT = 3;
`ifdef MAP_GEN_TERRAIN_EN
    localparam bit TERRAIN = 1'b1;
`else
    localparam bit TERRAIN = 1'b0;
`endif

    typedef struct {
        logic [14:0] addr;
        logic [3:0]  data;
        logic        last;
        logic        fill;
    } exp_t;

    typedef struct {
        logic [14:0] addr;
        logic [3:0]  data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    map_gen_if bus();

    map_gen #(
        .BASE_HEIGHT(BASE), .MIN_HEIGHT(MINH), .MAX_HEIGHT(MAXH), .DIRT_DEPTH(DIRT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t       sb[$];
    logic [3:0] mem [32768];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         prev_h = -1;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference map for one full fill, in write order.
    task automatic push_fill(input logic [15:0] sd);
        exp_t        e;
        int          h, hp, d;
        logic [15:0] l;
        logic [9:0]  col;
        logic [4:0]  yy;
        l  = (sd == 16'h0000) ? 16'hACE1 : sd;
        hp = BASE;
        for (int c = 0; c < 1024; c++) begin
            d = (l[1:0] == 2'b00) ? -1 : (l[1:0] == 2'b11) ? 1 : 0;
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            if (TERRAIN) begin
                h = hp + d;
                if (h < MINH) h = MINH;
                if (h > MAXH) h = MAXH;
            end else begin
                h = BASE;
            end
            hp = h;
            for (int y = 0; y < 32; y++) begin
                col    = c[9:0];
                yy     = y[4:0];
                e.addr = {yy, col};
                e.data = (y == 0) ? 4'd4 : (y > h) ? 4'd0 : (y == h) ? 4'd1 :
                         (y + DIRT >= h) ? 4'd2 : 4'd3;
                e.last = (c == 1023) && (y == 31);
                e.fill = 1'b1;
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   yv;
        if (bus.write_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", int'(bus.write_addr), int'(e.addr));
                check("wr_data", int'(bus.write_data), int'(e.data));
                if (e.last) begin
                    check("done_with_last", int'(bus.done), 1);
                    check("busy_after_last", int'(bus.busy), 0);
                end
                if (e.fill && bus.write_data == 4'd1) begin
                    yv = int'(bus.write_addr[14:10]);
                    check("h_in_range", int'(yv >= MINH && yv <= MAXH), 1);
                    if (prev_h >= 0)
                        check("h_adjacent", int'((yv - prev_h <= 1) && (prev_h - yv <= 1)), 1);
                    prev_h = yv;
                end
            end
            mem[bus.write_addr] = bus.write_data;
        end
    end

    task automatic start_fill(input logic [15:0] sd);
        @(posedge clk); #1;
        bus.seed  = sd;
        bus.start = 1'b1;
        prev_h    = -1;
        push_fill(sd);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int bad = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.edit_ready) bad++;
        end
        check("fill_done", int'(bus.done), 1);
        check("ready_low_in_fill", bad, 0);
    endtask

    vec_t edit_tbl [3];
    vec_t map_tbl  [5];

    initial begin
        edit_tbl[0] = '{15'h7FFF, 4'd5};
        edit_tbl[1] = '{15'h0000, 4'hF};
        edit_tbl[2] = '{15'h1234, 4'hA};
        map_tbl[0]  = '{15'h3000, 4'd1};
        map_tbl[1]  = '{15'h0000, 4'd4};
        map_tbl[2]  = '{15'h2C00, 4'd2};
        map_tbl[3]  = '{15'h1400, 4'd3};
        map_tbl[4]  = '{15'h3400, 4'd0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.seed       = 16'h0000;
        bus.edit_valid = 1'b0;
        bus.edit_addr  = '0;
        bus.edit_data  = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_write_en",   int'(bus.write_en), 0);
        check("rst_write_addr", int'(bus.write_addr), 0);
        check("rst_write_data", int'(bus.write_data), 0);
        check("rst_busy",       int'(bus.busy), 0);
        check("rst_done",       int'(bus.done), 0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("ready_after_rst", int'(bus.edit_ready), 1);

        // Edits while idle: one registered write each, a cycle after acceptance.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.edit_valid = 1'b1;
            bus.edit_addr  = edit_tbl[i].addr;
            bus.edit_data  = edit_tbl[i].data;
            sb.push_back('{edit_tbl[i].addr, edit_tbl[i].data, 1'b0, 1'b0});
            #1 check("idle_edit_ready", int'(bus.edit_ready), 1);
            @(posedge clk); #1 bus.edit_valid = 1'b0;
        end
        repeat (2) @(posedge clk); #1;
        check("idle_edits_drained", sb.size(), 0);

        // Fill aborted by reset mid-way.
        start_fill(16'h1234);
        repeat (5000) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_write_en", int'(bus.write_en), 0);
        check("abort_busy",     int'(bus.busy), 0);
        check("abort_done",     int'(bus.done), 0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        #1 check("ready_after_abort", int'(bus.edit_ready), 1);

        // Full fill with an edit held from cycle 100 until the fill finishes.
        start_fill(16'h0000);
        repeat (99) @(posedge clk);
        #1;
        bus.edit_valid = 1'b1;
        bus.edit_addr  = 15'h0421;
        bus.edit_data  = 4'd7;
        sb.push_back('{15'h0421, 4'd7, 1'b0, 1'b0});
        #1 check("ready_in_fill", int'(bus.edit_ready), 0);
        wait_done();
        @(posedge clk); #1 bus.edit_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("pending_edit_once", sb.size(), 0);
        check("done_holds_after_edit", int'(bus.done), 1);
`ifndef MAP_GEN_TERRAIN_EN
        for (int i = 0; i < 5; i++)
            check($sformatf("map_%h", map_tbl[i].addr), int'(mem[map_tbl[i].addr]), int'(map_tbl[i].data));
`endif

        // Restart from DONE with a coinciding edit, which must wait for the fill.
        @(posedge clk); #1;
        bus.seed       = 16'hACE1;
        bus.start      = 1'b1;
        bus.edit_valid = 1'b1;
        bus.edit_addr  = 15'h7C1F;
        bus.edit_data  = 4'd9;
        prev_h         = -1;
        push_fill(16'hACE1);
        sb.push_back('{15'h7C1F, 4'd9, 1'b0, 1'b0});
        #1 check("ready_with_start", int'(bus.edit_ready), 0);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        check("done_clears", int'(bus.done), 0);
        check("busy_on_restart", int'(bus.busy), 1);
        wait_done();
        @(posedge clk); #1 bus.edit_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("second_fill_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
